// File: rtl/lockstep_controller_if.sv
// Purpose: bundles the voter disagreement report with the per-core control outputs.
// Latency: n/a (wiring only).
// Backpressure: none; one report is presented and consumed every clock.
//
// Ports (signals):
//   voter_state   : 00 agree, 01/10/11 names the single disagreeing core (A/B/C)
//   no_majority   : all three cores disagree; overrides voter_state
//   core_hold     : per-core freeze, bit0=A bit1=B bit2=C
//   core_rst      : per-core resync reset
//   core_disable  : per-core sticky exclusion
//   system_halt   : sticky fatal error
//   fault_core    : last core declared faulty (00 = none yet)
//   transient_cnt : saturating count of mismatch episodes that cleared early
//   error_irq     : one-cycle pulse on fault declaration / entry to halt
interface lockstep_controller_if;
    logic [1:0] voter_state;
    logic       no_majority;
    logic [2:0] core_hold;
    logic [2:0] core_rst;
    logic [2:0] core_disable;
    logic       system_halt;
    logic [1:0] fault_core;
    logic [7:0] transient_cnt;
    logic       error_irq;

    // master: the voter / TMR top level side
    modport master (
        output voter_state,
        output no_majority,
        input  core_hold,
        input  core_rst,
        input  core_disable,
        input  system_halt,
        input  fault_core,
        input  transient_cnt,
        input  error_irq
    );

    // slave: the lockstep controller itself
    modport slave (
        input  voter_state,
        input  no_majority,
        output core_hold,
        output core_rst,
        output core_disable,
        output system_halt,
        output fault_core,
        output transient_cnt,
        output error_irq
    );
endinterface

// File: rtl/lockstep_controller.sv
// Purpose: turns TMR voter disagreement reports into hold/resync/disable/halt actions.
// Latency: all outputs registered; response visible one cycle after the report.
// Backpressure: none; a report is consumed every clock, nothing can be stalled.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_in : synchronous active-high reset; clears everything including sticky state
//   bus    : lockstep_controller_if.slave (voter report in, per-core controls out)
module lockstep_controller #(
    parameter int unsigned MISMATCH_THRESH = 4,  // 1..15
    parameter int unsigned RESYNC_CYCLES   = 8,  // 1..255
    parameter int unsigned MAX_RETRY       = 2   // 1..3
) (
    input  logic                  clk,
    input  logic                  rst_in,
    lockstep_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_RESYNC  = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    localparam logic [3:0] THRESH_M1  = 4'(MISMATCH_THRESH - 1);
    localparam logic [7:0] RESYNC_M1  = 8'(RESYNC_CYCLES - 1);
    localparam logic [1:0] RETRY_MAX  = 2'(MAX_RETRY);
    localparam bit         THRESH_ONE = (MISMATCH_THRESH == 1);

    // Core code (01/10/11) to one-hot lane (bit0=A). 00 maps to no lane.
    function automatic logic [2:0] core_bit(input logic [1:0] c);
        case (c)
            2'b01:   core_bit = 3'b001;
            2'b10:   core_bit = 3'b010;
            2'b11:   core_bit = 3'b100;
            default: core_bit = 3'b000;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t          state;
    logic [1:0]      cur_core;     // core under suspicion / being resynced
    logic [3:0]      mism_cnt;     // consecutive mismatches on cur_core
    logic [7:0]      rs_cnt;       // cycles spent in RESYNC
    logic [2:0][1:0] retry_cnt;    // resyncs consumed per core, saturating

    // Next-state values
    state_t          state_d;
    logic [1:0]      cur_d;
    logic [3:0]      mism_d;
    logic [7:0]      rs_d;
    logic [2:0][1:0] retry_d;
    logic [2:0]      dis_d;
    logic [1:0]      fault_d;
    logic [7:0]      tcnt_d;
    logic            irq_d;

    // Next registered output values
    logic [2:0]      hold_d;
    logic [2:0]      rst_d;
    logic            halt_d;

    // Report decode
    logic [2:0]      rpt_bit;
    logic            qual;        // mismatch naming an enabled core
    logic            decl;        // fault declared this cycle
    logic [1:0]      decl_core;
    logic [2:0]      decl_bit;
    logic [1:0]      retry_sel;
    logic            tinc;        // a suspect episode cleared early

    assign rpt_bit  = core_bit(bus.voter_state);
    assign qual     = (bus.voter_state != 2'b00) && ((rpt_bit & bus.core_disable) == 3'b000);
    assign decl_bit = core_bit(decl_core);

    // ------------------------------------------------------------------
    // Process 1: state register (also registers the outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state             <= ST_NORMAL;
            cur_core          <= 2'b00;
            mism_cnt          <= 4'd0;
            rs_cnt            <= 8'd0;
            retry_cnt         <= '0;
            bus.core_hold     <= 3'b000;
            bus.core_rst      <= 3'b000;
            bus.core_disable  <= 3'b000;
            bus.system_halt   <= 1'b0;
            bus.fault_core    <= 2'b00;
            bus.transient_cnt <= 8'd0;
            bus.error_irq     <= 1'b0;
        end else begin
            state             <= state_d;
            cur_core          <= cur_d;
            mism_cnt          <= mism_d;
            rs_cnt            <= rs_d;
            retry_cnt         <= retry_d;
            bus.core_hold     <= hold_d;
            bus.core_rst      <= rst_d;
            bus.core_disable  <= dis_d;
            bus.system_halt   <= halt_d;
            bus.fault_core    <= fault_d;
            bus.transient_cnt <= tcnt_d;
            bus.error_irq     <= irq_d;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state;
        cur_d     = cur_core;
        mism_d    = mism_cnt;
        rs_d      = rs_cnt;
        retry_d   = retry_cnt;
        dis_d     = bus.core_disable;
        fault_d   = bus.fault_core;
        tcnt_d    = bus.transient_cnt;
        irq_d     = 1'b0;
        decl      = 1'b0;
        decl_core = 2'b00;
        tinc      = 1'b0;
        retry_sel = 2'b00;

        case (state)
            ST_NORMAL: begin
                if (bus.no_majority) begin
                    state_d = ST_HALT;
                end else if (qual) begin
                    if (THRESH_ONE) begin
                        decl      = 1'b1;
                        decl_core = bus.voter_state;
                    end else begin
                        state_d = ST_SUSPECT;
                        cur_d   = bus.voter_state;
                        mism_d  = 4'd1;
                    end
                end
            end

            ST_SUSPECT: begin
                if (bus.no_majority) begin
                    state_d = ST_HALT;
                end else if (qual && (bus.voter_state == cur_core)) begin
                    if (mism_cnt == THRESH_M1) begin
                        decl      = 1'b1;
                        decl_core = cur_core;
                    end else begin
                        mism_d = mism_cnt + 4'd1;
                    end
                end else if (qual) begin
                    // Suspicion moves to another core: the old episode was transient.
                    tinc   = 1'b1;
                    cur_d  = bus.voter_state;
                    mism_d = 4'd1;
                end else begin
                    // Agreement, or a report about a disabled core.
                    tinc    = 1'b1;
                    state_d = ST_NORMAL;
                    mism_d  = 4'd0;
                end
            end

            ST_RESYNC: begin
                // Mismatches on the core being resynced are expected and ignored;
                // anything else means a second core is bad while one is offline.
                if (bus.no_majority || (qual && (bus.voter_state != cur_core))) begin
                    state_d = ST_HALT;
                    rs_d    = 8'd0;
                end else if (rs_cnt == RESYNC_M1) begin
                    state_d = ST_NORMAL;
                    rs_d    = 8'd0;
                end else begin
                    rs_d = rs_cnt + 8'd1;
                end
            end

            default: begin
                // ST_HALT: left only through rst_in
                state_d = ST_HALT;
            end
        endcase

        if (decl) begin
            fault_d = decl_core;
            mism_d  = 4'd0;
            for (int i = 0; i < 3; i++) begin
                if (decl_bit[i]) begin
                    retry_sel = retry_cnt[i];
                    if (retry_cnt[i] != 2'b11) begin
                        retry_d[i] = retry_cnt[i] + 2'd1;
                    end
                end
            end
            // Both a resync and a disable take the core out of the vote, so if
            // that leaves fewer than two enabled cores there is no majority left.
            if ($countones(~bus.core_disable & ~decl_bit) < 2) begin
                state_d = ST_HALT;
            end else if (retry_sel == RETRY_MAX) begin
                dis_d   = bus.core_disable | decl_bit;
                state_d = ST_NORMAL;
            end else begin
                state_d = ST_RESYNC;
                cur_d   = decl_core;
                rs_d    = 8'd0;
            end
        end

        if (tinc && (bus.transient_cnt != 8'hFF)) begin
            tcnt_d = bus.transient_cnt + 8'd1;
        end

        if (decl || ((state_d == ST_HALT) && (state != ST_HALT))) begin
            irq_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Process 3: output decode from the next state
    // ------------------------------------------------------------------
    always_comb begin
        hold_d = dis_d;
        rst_d  = 3'b000;
        halt_d = 1'b0;
        case (state_d)
            ST_HALT: begin
                hold_d = 3'b111;
                halt_d = 1'b1;
            end
            ST_RESYNC: begin
                hold_d = dis_d | core_bit(cur_d);
                rst_d  = core_bit(cur_d);
            end
            default: begin
                // disabled cores stay frozen, nothing in reset
                hold_d = dis_d;
            end
        endcase
    end

endmodule
